// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
//
// Sequential two's-complement to sign + BCD converter. One double-dabble
// shift per clock, start/busy/done handshake, result held until the next
// conversion completes. Feeds the seven-segment decoders, so it uses their
// digit codes: 4'hA marks overflow and 4'hB marks a blank digit.
//
// Parameters:
//   DATA_WIDTH  width of the two's-complement input word (>= 2)
//   DIGITS      number of BCD digits produced (1..10)
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   start         conversion request, only looked at in IDLE
//   outputEnable  0 forces blank codes on BCD and clears SIGNAL/OVERFLOW
//   DATA          two's-complement value, captured on the accepted start edge
//   busy          high while checking range and shifting
//   done          one-cycle pulse when a new result becomes valid
//   OVERFLOW      held result's magnitude exceeded 10^DIGITS-1
//   SIGNAL        held result is negative
//   BCD           result digits, most significant digit in the top nibble
//
// Build option:
//   BINARY_TO_BCD_LEADING_ZERO_BLANK_EN  when defined, leading zero digits of
//   a normal conversion are stored as blank (4'hB); the least significant
//   digit is never blanked.
//
// States:
//   S_IDLE  | waiting for start; result held
//   S_CHECK | range check of the captured magnitude
//   S_SHIFT | one double-dabble step per clock, MSB first
//   S_DONE  | one-cycle done pulse, back to idle

module binary_to_bcd_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int DIGITS     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    outputEnable,
    input  logic [DATA_WIDTH-1:0]   DATA,
    output logic                    busy,
    output logic                    done,
    output logic                    OVERFLOW,
    output logic                    SIGNAL,
    output logic [4*DIGITS-1:0]     BCD
);

    // 10^DIGITS needs 34 bits for ten digits, so it is built in 64 bits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MAXVALUE = pow10(DIGITS) - 64'd1;
    localparam int          CMP_W    = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;
    localparam int          BCD_W    = 4 * DIGITS;
    localparam int          CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] abs_reg;
    logic                  sign_reg;
    logic [BCD_W-1:0]      work;
    logic [CNT_W-1:0]      count;

    logic [BCD_W-1:0]      res_bcd;
    logic                  res_sign;
    logic                  res_ovf;

    logic capture;
    logic load_ovf;
    logic init_shift;
    logic shift_en;
    logic load_res;

    logic                  over_range;
    logic [DATA_WIDTH-1:0] data_neg;
    logic [BCD_W-1:0]      next_work;
    logic [DATA_WIDTH-1:0] next_abs;
    logic [BCD_W-1:0]      final_digits;

    // Magnitude of the most negative input wraps to 2^(DATA_WIDTH-1), which
    // is the intended unsigned reading.
    assign data_neg   = (~DATA) + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign over_range = CMP_W'(abs_reg) > CMP_W'(MAXVALUE);
    assign next_abs   = {abs_reg[DATA_WIDTH-2:0], 1'b0};

    // Add-3-then-shift, expressed per digit. A digit >= 5 after +3 always
    // has bit 3 set (digits stay 0..9), so the bit shifted into the next
    // digit is simply (digit >= 5), and the low three bits of the adjusted
    // digit equal a 3-bit wrap-around add.
    always_comb begin
        next_work = '0;
        if (work[3:0] >= 4'd5) begin
            next_work[3:1] = work[2:0] + 3'd3;
        end else begin
            next_work[3:1] = work[2:0];
        end
        next_work[0] = abs_reg[DATA_WIDTH-1];
        for (int i = 1; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                next_work[4*i+1 +: 3] = work[4*i +: 3] + 3'd3;
            end else begin
                next_work[4*i+1 +: 3] = work[4*i +: 3];
            end
            next_work[4*i] = (work[4*(i-1) +: 4] >= 4'd5);
        end
    end

`ifdef BINARY_TO_BCD_LEADING_ZERO_BLANK_EN
    // Blank zeros from the MSD down to the first nonzero digit; digit 0 is
    // left alone so a zero result still shows a single 0.
    always_comb begin
        logic leading;
        final_digits = next_work;
        leading      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (next_work[4*i +: 4] == 4'h0)) begin
                final_digits[4*i +: 4] = 4'hB;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign final_digits = next_work;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        load_ovf   = 1'b0;
        init_shift = 1'b0;
        shift_en   = 1'b0;
        load_res   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (over_range) begin
                    load_ovf   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    init_shift = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (count == '0) begin
                    load_res   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            abs_reg  <= '0;
            sign_reg <= 1'b0;
            work     <= '0;
            count    <= '0;
            res_bcd  <= '0;
            res_sign <= 1'b0;
            res_ovf  <= 1'b0;
        end else begin
            if (capture) begin
                abs_reg  <= DATA[DATA_WIDTH-1] ? data_neg : DATA;
                sign_reg <= DATA[DATA_WIDTH-1];
            end
            if (load_ovf) begin
                res_bcd  <= {DIGITS{4'hA}};
                res_ovf  <= 1'b1;
                res_sign <= sign_reg;
            end
            if (init_shift) begin
                work  <= '0;
                count <= CNT_INIT;
            end
            if (shift_en) begin
                work    <= next_work;
                abs_reg <= next_abs;
                count   <= count - CNT_W'(1);
            end
            if (load_res) begin
                res_bcd  <= final_digits;
                res_ovf  <= 1'b0;
                res_sign <= sign_reg;
            end
        end
    end

    // Display gating only; handshake outputs are never gated.
    assign BCD      = outputEnable ? res_bcd : {DIGITS{4'hB}};
    assign SIGNAL   = outputEnable & res_sign;
    assign OVERFLOW = outputEnable & res_ovf;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
module tb_binary_to_bcd_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic        outputEnable;
    logic [31:0] DATA;
    logic        busy;
    logic        done;
    logic        OVERFLOW;
    logic        SIGNAL;
    logic [15:0] BCD;

    int checks;
    int failures;

    binary_to_bcd_seq #(
        .DATA_WIDTH (32),
        .DIGITS     (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .outputEnable (outputEnable),
        .DATA         (DATA),
        .busy         (busy),
        .done         (done),
        .OVERFLOW     (OVERFLOW),
        .SIGNAL       (SIGNAL),
        .BCD          (BCD)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef BINARY_TO_BCD_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP_M123 = 16'hB123;
    localparam logic [15:0] EXP_42   = 16'hBB42;
    localparam logic [15:0] EXP_ZERO = 16'hBBB0;
`else
    localparam logic [15:0] EXP_M123 = 16'h0123;
    localparam logic [15:0] EXP_42   = 16'h0042;
    localparam logic [15:0] EXP_ZERO = 16'h0000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches a conversion on the next rising edge (cycle 0) and watches
    // the cycles after it. Cycle c is sampled on the falling edge following
    // edge c-1. Optionally re-pulses start with new DATA at inject_cycle.
    task automatic run_conv(input logic [31:0] d, input int inject_cycle,
                            input logic [31:0] inject_data,
                            output int done_cycle, output int busy_cycles,
                            output logic [15:0] mid_bcd);
        @(negedge clock);
        DATA  = d;
        start = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        done_cycle  = -1;
        busy_cycles = 0;
        mid_bcd     = 16'hxxxx;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 5) mid_bcd = BCD;
            if (busy) busy_cycles++;
            if (c == inject_cycle) begin
                start = 1'b1;
                DATA  = inject_data;
            end
            if (c == inject_cycle + 1) start = 1'b0;
            if (done) begin
                done_cycle = c;
                break;
            end
        end
    endtask

    int          dc;
    int          bc;
    logic [15:0] mb;
    int          done_seen;
    int          busy_seen;

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        start        = 1'b0;
        outputEnable = 1'b1;
        DATA         = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("reset_bcd",  BCD,      16'h0000);
        check("reset_sign", SIGNAL,   1'b0);
        check("reset_ovf",  OVERFLOW, 1'b0);
        check("reset_busy", busy,     1'b0);
        check("reset_done", done,     1'b0);

        run_conv(32'd1234, 0, 32'd0, dc, bc, mb);
        check("p1234_done_cycle", dc, 34);
        check("p1234_busy_cycles", bc, 33);
        check("p1234_bcd",  BCD,      16'h1234);
        check("p1234_sign", SIGNAL,   1'b0);
        check("p1234_ovf",  OVERFLOW, 1'b0);
        @(negedge clock);
        check("p1234_done_one_cycle", done, 1'b0);
        check("p1234_idle_busy", busy, 1'b0);

        run_conv(32'hFFFFFF85, 0, 32'd0, dc, bc, mb);
        check("m123_hold_prev", mb, 16'h1234);
        check("m123_done_cycle", dc, 34);
        check("m123_bcd",  BCD,    EXP_M123);
        check("m123_sign", SIGNAL, 1'b1);

        run_conv(32'd10000, 0, 32'd0, dc, bc, mb);
        check("ovf10000_done_cycle", dc, 2);
        check("ovf10000_bcd",  BCD,      16'hAAAA);
        check("ovf10000_ovf",  OVERFLOW, 1'b1);
        check("ovf10000_sign", SIGNAL,   1'b0);

        run_conv(32'h80000000, 0, 32'd0, dc, bc, mb);
        check("ovfmin_done_cycle", dc, 2);
        check("ovfmin_bcd",  BCD,      16'hAAAA);
        check("ovfmin_ovf",  OVERFLOW, 1'b1);
        check("ovfmin_sign", SIGNAL,   1'b1);

        // 9999 is the largest magnitude that still converts normally.
        run_conv(32'd9999, 10, 32'd5, dc, bc, mb);
        check("p9999_done_cycle", dc, 34);
        check("p9999_bcd", BCD,      16'h9999);
        check("p9999_ovf", OVERFLOW, 1'b0);
        repeat (2) @(negedge clock);
        check("p9999_no_restart", busy, 1'b0);

        // Second conversion aborted by reset mid-SHIFT.
        @(negedge clock);
        DATA  = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_bcd",  BCD,  16'h0000);
        check("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_no_busy", busy_seen, 0);
        check("abort_bcd_after", BCD, 16'h0000);

        run_conv(32'hFFFFFFD6, 0, 32'd0, dc, bc, mb);
        check("m42_done_cycle", dc, 34);
        check("m42_bcd",  BCD,    EXP_42);
        check("m42_sign", SIGNAL, 1'b1);
        @(negedge clock);
        outputEnable = 1'b0;
        #1;
        check("gate_bcd",  BCD,      16'hBBBB);
        check("gate_sign", SIGNAL,   1'b0);
        check("gate_ovf",  OVERFLOW, 1'b0);
        repeat (3) @(negedge clock);
        outputEnable = 1'b1;
        #1;
        check("ungate_bcd",  BCD,    EXP_42);
        check("ungate_sign", SIGNAL, 1'b1);
        check("ungate_busy", busy,   1'b0);

        run_conv(32'd0, 0, 32'd0, dc, bc, mb);
        check("zero_done_cycle", dc, 34);
        check("zero_bcd",  BCD,    EXP_ZERO);
        check("zero_sign", SIGNAL, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
